fragment_collector: RTL

//  Consumer of the bounding-box traverser's fragment write port (wr_data/wr_addr/wr_en).

---
 rtl/fragment_collector_if.sv | 27 ++
 rtl/fragment_collector.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fragment_collector_if.sv
// Fragment word stream from the traverser plus the downstream head-fragment port.
// The collector uses the slave side; the traverser and consumer use the master side.
interface fragment_collector_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_en;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_x;
  logic [DATA_WIDTH-1:0] out_y;
  logic [ADDR_WIDTH-1:0] out_attr_addr;
  logic [DATA_WIDTH-1:0] out_attr_data;

  modport master (
    output wr_data, wr_addr, wr_en, out_ready, out_attr_addr,
    input  out_valid, out_x, out_y, out_attr_data
  );

  modport slave (
    input  wr_data, wr_addr, wr_en, out_ready, out_attr_addr,
    output out_valid, out_x, out_y, out_attr_data
  );
endinterface

// File: rtl/fragment_collector.sv
// Assembles fragments (x, y, attributes) from the traverser word stream into a
// two-bank ping-pong buffer and presents the oldest complete one downstream.
module fragment_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] vertexSize,
  output logic                  space_avail,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  protocol_err,
  fragment_collector_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {COL_X, COL_Y, COL_ATTR} col_state_e;

  col_state_e state_q, state_d;
  logic [1:0] count_q, count_d;
  logic       wbank_q, wbank_d;
  logic       rbank_q, rbank_d;
  logic       overflow_q, overflow_d;
  logic       perr_q, perr_d;

  logic [DATA_WIDTH-1:0] x_q    [2];
  logic [DATA_WIDTH-1:0] y_q    [2];
  logic [DATA_WIDTH-1:0] attr_q [2][DEPTH];

  logic x_we, y_we, attr_we;
  logic commit, pop;
  logic out_valid;

  assign out_valid = (count_q != 2'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= COL_X;
      count_q    <= 2'd0;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      overflow_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      overflow_q <= overflow_d;
      perr_q     <= perr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wbank_d    = wbank_q;
    rbank_d    = rbank_q;
    overflow_d = overflow_q;
    perr_d     = perr_q;
    x_we       = 1'b0;
    y_we       = 1'b0;
    attr_we    = 1'b0;
    commit     = 1'b0;
    pop        = 1'b0;

    if (en) begin
      if (clear) begin
        state_d    = COL_X;
        count_d    = 2'd0;
        wbank_d    = 1'b0;
        rbank_d    = 1'b0;
        overflow_d = 1'b0;
        perr_d     = 1'b0;
      end else begin
        pop = out_valid & bus.out_ready;
        // Count is sampled before any same-cycle pop, so a full buffer drops the word.
        if (bus.wr_en) begin
          if (count_q == 2'd2) begin
            overflow_d = 1'b1;
            state_d    = COL_X;
          end else begin
            case (state_q)
              COL_X: begin
                if (bus.wr_addr == '0) begin
                  x_we    = 1'b1;
                  state_d = COL_Y;
                end else begin
                  perr_d  = 1'b1;
                end
              end
              COL_Y: begin
                if (bus.wr_addr == ADDR_WIDTH'(1)) begin
                  y_we    = 1'b1;
                  state_d = COL_ATTR;
                end else begin
                  perr_d  = 1'b1;
                  state_d = COL_X;
                end
              end
              COL_ATTR: begin
                if (bus.wr_addr <= vertexSize) begin
                  attr_we = 1'b1;
                  if (bus.wr_addr == vertexSize) begin
                    commit  = 1'b1;
                    state_d = COL_X;
                  end
                end else begin
                  perr_d = 1'b1;
                end
              end
              default: state_d = COL_X;
            endcase
          end
        end

        if (commit) wbank_d = ~wbank_q;
        if (pop)    rbank_d = ~rbank_q;
        if (commit && !pop)      count_d = count_q + 2'd1;
        else if (pop && !commit) count_d = count_q - 2'd1;
      end
    end
  end

  // Fragment storage; the write bank is never the head bank while it is being filled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int b = 0; b < 2; b++) begin
        x_q[b] <= '0;
        y_q[b] <= '0;
        for (int a = 0; a < DEPTH; a++) begin
          attr_q[b][a] <= '0;
        end
      end
    end else begin
      if (x_we)    x_q[wbank_q] <= bus.wr_data;
      if (y_we)    y_q[wbank_q] <= bus.wr_data;
      if (attr_we) attr_q[wbank_q][bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.out_valid     = out_valid;
  assign bus.out_x         = x_q[rbank_q];
  assign bus.out_y         = y_q[rbank_q];
  assign bus.out_attr_data = attr_q[rbank_q][bus.out_attr_addr];

  assign space_avail  = (count_q != 2'd2);
  assign full         = (count_q == 2'd2);
  assign empty        = (count_q == 2'd0);
  assign overflow     = overflow_q;
  assign protocol_err = perr_q;

endmodule
